// File: rtl/patgen_pkg.sv
// Shared types and constants for the synthetic Bayer frame source (ccd_pattern_gen).
package patgen_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      HBLANK = 2'd2,
      VBLANK = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      RAMP_H  = 2'd0,
      RAMP_V  = 2'd1,
      CHECKER = 2'd2,
      BARS    = 2'd3
   } mode_t;

   // Bayer site index is {row[0], col[0]}
   localparam logic [1:0] SITE_G1 = 2'b00;
   localparam logic [1:0] SITE_R  = 2'b01;
   localparam logic [1:0] SITE_B  = 2'b10;
   localparam logic [1:0] SITE_G2 = 2'b11;

   localparam int unsigned LFSR_W = 16;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
   // Taps 16,14,13,11 expressed as bit positions 0,2,3,5 of a right-shifting register
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

   // Colour-bar channel bits: R=bar[2], G=bar[1], B=bar[0]
   function automatic logic barSiteOn(input logic [1:0] site, input logic [2:0] bar);
      case (site)
         SITE_R:  barSiteOn = bar[2];
         SITE_B:  barSiteOn = bar[0];
         default: barSiteOn = bar[1];
      endcase
   endfunction

endpackage

// File: rtl/patgen_lfsr.sv
// 16-bit Fibonacci LFSR used as low-order pixel noise by ccd_pattern_gen.
module patgen_lfsr
   import patgen_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              advance,
   input  logic              reseed,
   output logic [LFSR_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || reseed) begin
         q <= LFSR_SEED;
      end else if (advance) begin
         q <= {^(q & LFSR_TAPS), q[LFSR_W-1:1]};
      end
   end

endmodule

// File: rtl/ccd_pattern_gen.sv
// Synthetic raw Bayer frame source with full line/frame timing and four test patterns.
// Optional low-nibble LFSR noise is enabled by defining PATGEN_LFSR_NOISE_EN.
module ccd_pattern_gen
   import patgen_pkg::*;
#(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned H_BLANK  = 16,
   parameter int unsigned V_BLANK  = 4,
   parameter int unsigned DATA_W   = 12
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iSTART,
   input  logic [1:0]        iMODE,
   output logic [DATA_W-1:0] oDATA,
   output logic              oDVAL,
   output logic [15:0]       oX_Cont,
   output logic [15:0]       oY_Cont,
   output logic              oFRAME_DONE,
   output logic [31:0]       oFrame_Cont
);

   localparam int unsigned VBLANK_LEN = V_BLANK * (H_ACTIVE + H_BLANK);
   localparam int unsigned BLANK_MAX  = (VBLANK_LEN > H_BLANK) ? VBLANK_LEN : H_BLANK;
   localparam int unsigned BLANK_W    = $clog2(BLANK_MAX + 1);
   localparam int unsigned BAR_W      = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
   localparam int unsigned BAR_CW     = $clog2(BAR_W) + 1;
   localparam logic [DATA_W-1:0] FULL = '1;

   state_t              state, stateNext;
   mode_t               mode, modeNext;
   logic [15:0]         xCnt, xNext, yCnt, yNext;
   logic [BLANK_W-1:0]  blankCnt, blankNext;
   logic [BAR_CW-1:0]   barPix, barPixNext;
   logic [2:0]          barIdx, barIdxNext;

   logic [DATA_W-1:0]   dataNext, pattern, pixel;
   logic                dvalNext, doneNext;
   logic [15:0]         xOutNext, yOutNext;
   logic [31:0]         frameNext;
   logic [1:0]          site;

   // Pattern value for the pixel the counters currently point at
   always_comb begin
      site    = {yCnt[0], xCnt[0]};
      pattern = '0;
      case (mode)
         RAMP_H:  pattern = DATA_W'(xCnt[11:0]);
         RAMP_V:  pattern = DATA_W'(yCnt[11:0]);
         CHECKER: pattern = (xCnt[3] ^ yCnt[3]) ? FULL : '0;
         BARS:    pattern = barSiteOn(site, barIdx) ? FULL : '0;
         default: pattern = '0;
      endcase
   end

`ifdef PATGEN_LFSR_NOISE_EN
   logic [LFSR_W-1:0] lfsrQ;
   logic              frameStart;

   assign frameStart = (state == IDLE || state == VBLANK) && (stateNext == ACTIVE);

   patgen_lfsr uLfsr (
      .clk     (iCLK),
      .rst     (iRST),
      .advance (state == ACTIVE),
      .reseed  (frameStart),
      .q       (lfsrQ)
   );

   assign pixel = pattern ^ DATA_W'(lfsrQ[3:0]);
`else
   assign pixel = pattern;
`endif

   // Next-state, counters and next output values
   always_comb begin
      stateNext  = state;
      modeNext   = mode;
      xNext      = xCnt;
      yNext      = yCnt;
      blankNext  = blankCnt;
      barPixNext = barPix;
      barIdxNext = barIdx;
      dvalNext   = 1'b0;
      dataNext   = '0;
      xOutNext   = '0;
      yOutNext   = oY_Cont;
      doneNext   = 1'b0;
      frameNext  = oFrame_Cont;

      case (state)
         IDLE: begin
            if (iSTART) begin
               stateNext  = ACTIVE;
               modeNext   = mode_t'(iMODE);
               xNext      = '0;
               yNext      = '0;
               barPixNext = '0;
               barIdxNext = '0;
            end
         end

         ACTIVE: begin
            dvalNext = 1'b1;
            dataNext = pixel;
            xOutNext = xCnt;
            yOutNext = yCnt;
            xNext    = xCnt + 16'd1;
            if (barPix == BAR_CW'(BAR_W - 1)) begin
               barPixNext = '0;
               barIdxNext = barIdx + 3'd1;
            end else begin
               barPixNext = barPix + BAR_CW'(1);
            end
            if (xCnt == 16'(H_ACTIVE - 1)) begin
               stateNext = HBLANK;
               blankNext = '0;
            end
         end

         HBLANK: begin
            // First blank cycle after the last pixel of the frame
            if (blankCnt == '0 && yCnt == 16'(V_ACTIVE - 1)) begin
               doneNext  = 1'b1;
               frameNext = oFrame_Cont + 32'd1;
            end
            blankNext = blankCnt + BLANK_W'(1);
            if (blankCnt == BLANK_W'(H_BLANK - 1)) begin
               blankNext = '0;
               if (yCnt < 16'(V_ACTIVE - 1)) begin
                  stateNext  = ACTIVE;
                  yNext      = yCnt + 16'd1;
                  xNext      = '0;
                  barPixNext = '0;
                  barIdxNext = '0;
               end else begin
                  stateNext = VBLANK;
               end
            end
         end

         VBLANK: begin
            blankNext = blankCnt + BLANK_W'(1);
            if (blankCnt == BLANK_W'(VBLANK_LEN - 1)) begin
               blankNext = '0;
               if (iSTART) begin
                  stateNext  = ACTIVE;
                  modeNext   = mode_t'(iMODE);
                  xNext      = '0;
                  yNext      = '0;
                  barPixNext = '0;
                  barIdxNext = '0;
               end else begin
                  stateNext = IDLE;
               end
            end
         end

         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state       <= IDLE;
         mode        <= RAMP_H;
         xCnt        <= '0;
         yCnt        <= '0;
         blankCnt    <= '0;
         barPix      <= '0;
         barIdx      <= '0;
         oDATA       <= '0;
         oDVAL       <= 1'b0;
         oX_Cont     <= '0;
         oY_Cont     <= '0;
         oFRAME_DONE <= 1'b0;
         oFrame_Cont <= '0;
      end else begin
         state       <= stateNext;
         mode        <= modeNext;
         xCnt        <= xNext;
         yCnt        <= yNext;
         blankCnt    <= blankNext;
         barPix      <= barPixNext;
         barIdx      <= barIdxNext;
         oDATA       <= dataNext;
         oDVAL       <= dvalNext;
         oX_Cont     <= xOutNext;
         oY_Cont     <= yOutNext;
         oFRAME_DONE <= doneNext;
         oFrame_Cont <= frameNext;
      end
   end

endmodule
